// File: rtl/rr_mux_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_pkg
// Shared definitions for the round-robin N-to-1 multiplexer:
//   - state_e          : output register occupancy (EMPTY / FULL)
//   - DEFAULT_WIDTH    : default data bits per channel
//   - DEFAULT_CHANNELS : default number of input channels
//   - clog2()          : index width helper, never returns less than 1 so a
//                        select field always has at least one bit
// -----------------------------------------------------------------------------
package rr_mux_pkg;

  // Occupancy of the single output register.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH    = 32'sd4;
  localparam int DEFAULT_CHANNELS = 32'sd4;

  // Number of bits needed to index 'value' items (minimum 1).
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 32'sd1;
      end else begin
        result = result;
      end
    end
    if (result < 32'sd1) begin
      result = 32'sd1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage : rr_mux_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at the channel
// just above 'ptr' (the last channel served) and wraps modulo CHANNELS, so the
// most recently served channel has the lowest priority.
//
// Ports:
//   req       [CHANNELS-1:0] in  : per-channel request
//   ptr       [SEL_W-1:0]    in  : index of the last channel granted
//   grant     [CHANNELS-1:0] out : one-hot grant, all zero when nothing requests
//   grant_idx [SEL_W-1:0]    out : binary index of the granted channel
//                                  (0 when no grant; qualify with |grant)
// -----------------------------------------------------------------------------
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int SEL_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  logic [SEL_W-1:0] cand_idx;
  logic             found;

  // Walk the channels in priority order (ptr+1, ptr+2, ... wrapping) and take
  // the first requester. The modulo keeps every candidate below CHANNELS even
  // for non-power-of-two channel counts or an out-of-range ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand_idx  = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand_idx = SEL_W'((int'(ptr) + k) % CHANNELS);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end else begin
        found = found;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/rr_mux_n_to_1.sv
// -----------------------------------------------------------------------------
// rr_mux_n_to_1
// Round-robin N-to-1 multiplexer with a single registered output stage.
// Each load opportunity (output register empty, or being drained this cycle)
// grants one valid input channel in round-robin order; the granted word is
// captured into out_data with one cycle of latency. A drain and a new load can
// happen in the same cycle, so a continuously fed output never bubbles.
//
// Optional feature (compile-time macro RR_MUX_FORCE_SEL_EN):
//   adds force_en / force_sel. While force_en is high the grant is force_sel
//   (only if that channel is valid and in range) and the round-robin pointer
//   is left untouched, so rotation resumes where it left off afterwards.
//
// Ports:
//   clk        in   1                 rising-edge clock
//   rst        in   1                 synchronous active-high reset
//   force_en   in   1                 (RR_MUX_FORCE_SEL_EN only) force select
//   force_sel  in   SEL_W             (RR_MUX_FORCE_SEL_EN only) forced channel
//   in_data    in   CHANNELS*WIDTH    channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   CHANNELS          per-channel data valid
//   in_ready   out  CHANNELS          per-channel accept, at most one hot
//   out_data   out  WIDTH             registered selected data
//   out_sel    out  SEL_W             channel index held in out_data
//   out_valid  out  1                 out_data / out_sel valid
//   out_ready  in   1                 downstream accept
// -----------------------------------------------------------------------------
module rr_mux_n_to_1
  import rr_mux_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int CHANNELS = DEFAULT_CHANNELS,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef RR_MUX_FORCE_SEL_EN
  input  logic                      force_en,
  input  logic [SEL_W-1:0]          force_sel,
`endif
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Registered state: occupancy, held word, its channel, round-robin pointer.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;

  // Arbitration results.
  logic [CHANNELS-1:0] arb_grant;
  logic [SEL_W-1:0]    arb_idx;
  logic                grant_vld;  // some channel is selected this cycle
  logic [SEL_W-1:0]    grant_idx;  // selected channel index
  logic                forced;     // selection came from force_sel
  logic                load_en;    // output register can take a new word
  logic                take;       // an input transfer completes this cycle

  // Per-channel view of the packed input bus.
  logic [WIDTH-1:0] chan_word [CHANNELS];

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arbiter (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Unpack the flat input bus so the data mux indexes by channel number.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      chan_word[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Choose the channel to serve: round-robin by default, or the forced
  // channel when the override is compiled in and active.
  always_comb begin
    grant_vld = |arb_grant;
    grant_idx = arb_idx;
    forced    = 1'b0;
`ifdef RR_MUX_FORCE_SEL_EN
    if (force_en) begin
      forced = 1'b1;
      if (int'(force_sel) < CHANNELS) begin
        if (in_valid[force_sel]) begin
          grant_vld = 1'b1;
          grant_idx = force_sel;
        end else begin
          grant_vld = 1'b0;
          grant_idx = '0;
        end
      end else begin
        // Out-of-range forced index never grants.
        grant_vld = 1'b0;
        grant_idx = '0;
      end
    end else begin
      forced = 1'b0;
    end
`endif
  end

  // Handshake: a load slot exists when the register is empty or being drained.
  // rst gates the transfer so nothing is accepted while reset is asserted.
  // in_ready depends only on in_valid, ptr, state, out_ready (never in_data).
  always_comb begin
    load_en  = (state_q == EMPTY) | out_ready;
    take     = load_en & grant_vld & ~rst;
    in_ready = '0;
    if (take) begin
      in_ready[grant_idx] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Next-state logic for the output stage and the round-robin pointer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (take) begin
      state_d = FULL;
      data_d  = chan_word[grant_idx];
      sel_d   = grant_idx;
      // A forced transfer leaves the rotation where it was.
      if (forced) begin
        ptr_d = ptr_q;
      end else begin
        ptr_d = grant_idx;
      end
    end else if (load_en) begin
      // Drained (or already empty) with nothing to load: go empty, keep
      // the last word, channel and pointer.
      state_d = EMPTY;
    end else begin
      // FULL and stalled: everything holds.
      state_d = state_q;
    end
  end

  // State registers; reset leaves ptr at the last channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(CHANNELS - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = (state_q == FULL);

endmodule : rr_mux_n_to_1

// File: tb/tb_rr_mux_n_to_1.sv
// -----------------------------------------------------------------------------
// Testbench for rr_mux_n_to_1.
//   u_dut4 : CHANNELS=4, WIDTH=4 (directed table, random vs. model, force)
//   u_dut3 : CHANNELS=3, WIDTH=8 (non-power-of-two wrap)
// -----------------------------------------------------------------------------
module tb_rr_mux_n_to_1;

  logic clk;
  int   checks;
  int   errors;

  // 4-channel DUT signals
  logic        rst4;
  logic [15:0] data4;
  logic [3:0]  valid4;
  logic [3:0]  in_ready4;
  logic [3:0]  out_data4;
  logic [1:0]  out_sel4;
  logic        out_valid4;
  logic        ordy4;
  logic        f_en;
  logic [1:0]  f_sel;

  // 3-channel DUT signals
  logic        rst3;
  logic [23:0] data3;
  logic [2:0]  valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_valid3;
  logic        ordy3;
  logic        f_en3;
  logic [1:0]  f_sel3;

  rr_mux_n_to_1 #(.WIDTH(4), .CHANNELS(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst4),
`ifdef RR_MUX_FORCE_SEL_EN
    .force_en  (f_en),
    .force_sel (f_sel),
`endif
    .in_data   (data4),
    .in_valid  (valid4),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_sel   (out_sel4),
    .out_valid (out_valid4),
    .out_ready (ordy4)
  );

  rr_mux_n_to_1 #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst3),
`ifdef RR_MUX_FORCE_SEL_EN
    .force_en  (f_en3),
    .force_sel (f_sel3),
`endif
    .in_data   (data3),
    .in_valid  (valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_valid (out_valid3),
    .out_ready (ordy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Directed vector: inputs applied for one cycle, expected in_ready during
  // that cycle and expected registered outputs after the edge.
  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic [1:0] exp_sel;
    logic [3:0] exp_data;
  } vec_t;

  vec_t vq[$];

  // Reference model state for the 4-channel DUT.
  logic       m_valid;
  logic [3:0] m_data;
  int         m_sel;
  int         m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Which channel should be served: the first valid one after ptr, wrapping
  // over n channels; or the forced channel if valid. -1 means no grant.
  function automatic int model_pick(input logic [15:0] v, input int ptr, input int n,
                                    input logic fen, input int fsel);
    int idx;
    if (fen) begin
      if (fsel < n && ((v >> fsel) & 16'd1) != 16'd0) return fsel;
      return -1;
    end
    for (int k = 1; k <= n; k++) begin
      idx = (ptr + k) % n;
      if (((v >> idx) & 16'd1) != 16'd0) return idx;
    end
    return -1;
  endfunction

  // One random/model-checked cycle on the 4-channel DUT.
  task automatic rand_step(input logic r, input logic [3:0] v, input logic o, input logic [15:0] d);
    int   g;
    logic load;
    rst4   = r;
    valid4 = v;
    ordy4  = o;
    data4  = d;
    @(negedge clk);
    load = !m_valid || o;
    g = -1;
    if (!r && load) g = model_pick({12'd0, v}, m_ptr, 4, f_en, int'(f_sel));
    check("model in_ready", {28'd0, in_ready4}, (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0; m_data = 4'd0; m_sel = 0; m_ptr = 3;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = 4'(d >> (4 * g));
      m_sel   = g;
      if (!f_en) m_ptr = g;
    end else if (load) begin
      m_valid = 1'b0;
    end
    check("model out_valid", {31'd0, out_valid4}, {31'd0, m_valid});
    check("model out_sel", {30'd0, out_sel4}, 32'(m_sel));
    check("model out_data", {28'd0, out_data4}, {28'd0, m_data});
  endtask

  initial begin
    logic [7:0] exp3_data [3];
    checks = 0;
    errors = 0;
    f_en   = 1'b0;  f_sel  = 2'd0;
    f_en3  = 1'b0;  f_sel3 = 2'd0;
    rst3   = 1'b1;  valid3 = 3'b000; ordy3 = 1'b0; data3 = 24'h332211;
    rst4   = 1'b1;  valid4 = 4'b0000; ordy4 = 1'b0;
    data4  = 16'hDCBA;  // ch0=A ch1=B ch2=C ch3=D

    // ---------------- directed table on the 4-channel DUT ----------------
    //             rst   valid    ordy  ready    ov    sel    data
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0}); // reset
    vq.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA}); // fairness
    vq.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB});
    vq.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC});
    vq.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD});
    vq.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA});
    vq.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB});
    vq.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC});
    vq.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 4'hC}); // backpressure
    vq.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 4'hC});
    vq.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 4'hC});
    vq.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD}); // resume at 3
    vq.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA}); // ptr=0
    vq.push_back('{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD}); // sparse
    vq.push_back('{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA}); // wrap
    vq.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'hA}); // drain
    vq.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'hA}); // idle empty
    vq.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 4'hC}); // load from empty
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0}); // mid-op reset
    vq.push_back('{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 4'hB}); // single channel
    vq.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB});
    vq.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB});

    for (int i = 0; i < vq.size(); i++) begin
      rst4   = vq[i].rst;
      valid4 = vq[i].valid;
      ordy4  = vq[i].ordy;
      @(negedge clk);
      check($sformatf("vec%0d in_ready", i), {28'd0, in_ready4}, {28'd0, vq[i].exp_ready});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), {31'd0, out_valid4}, {31'd0, vq[i].exp_ov});
      check($sformatf("vec%0d out_sel", i), {30'd0, out_sel4}, {30'd0, vq[i].exp_sel});
      check($sformatf("vec%0d out_data", i), {28'd0, out_data4}, {28'd0, vq[i].exp_data});
    end

    // ---------------- 3-channel wrap: 0,1,2,0 ----------------
    exp3_data[0] = 8'h11; exp3_data[1] = 8'h22; exp3_data[2] = 8'h33;
    rst3 = 1'b1; valid3 = 3'b111; ordy3 = 1'b1;
    @(negedge clk);
    check("ch3 reset in_ready", {29'd0, in_ready3}, 32'd0);
    @(posedge clk);
    #1;
    check("ch3 reset out_valid", {31'd0, out_valid3}, 32'd0);
    rst3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("ch3 step%0d in_ready", i), {29'd0, in_ready3}, 32'd1 << (i % 3));
      @(posedge clk);
      #1;
      check($sformatf("ch3 step%0d out_sel", i), {30'd0, out_sel3}, 32'(i % 3));
      check($sformatf("ch3 step%0d out_data", i), {24'd0, out_data3}, {24'd0, exp3_data[i % 3]});
      check($sformatf("ch3 step%0d out_valid", i), {31'd0, out_valid3}, 32'd1);
    end

    // ---------------- randomized vs. reference model ----------------
    rand_step(1'b1, 4'b1111, 1'b1, 16'(data4));
    for (int i = 0; i < 600; i++) begin
      rand_step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                16'($urandom));
    end

`ifdef RR_MUX_FORCE_SEL_EN
    // ---------------- forced select ----------------
    rand_step(1'b1, 4'b1111, 1'b1, 16'hDCBA);
    rand_step(1'b0, 4'b1111, 1'b1, 16'hDCBA);   // grant 0, ptr=0
    f_en = 1'b1; f_sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      rand_step(1'b0, 4'b1111, 1'b1, 16'hDCBA);
      check("force out_sel", {30'd0, out_sel4}, 32'd2);
    end
    rand_step(1'b0, 4'b1011, 1'b1, 16'hDCBA);   // forced channel idle
    check("force idle out_valid", {31'd0, out_valid4}, 32'd0);
    f_en = 1'b0;
    rand_step(1'b0, 4'b1111, 1'b1, 16'hDCBA);
    check("force release out_sel", {30'd0, out_sel4}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rr_mux_n_to_1
